bram_host_agent: RTL and testbench
==================================

Name: bram_host_agent

Overview:
- Responder/host end of the PE controller's BRAM interface. Owns the shared word memory that the controller reads its 64x64 matrix and 64-vector from, and that it writes its result word into.
- Host side: a streaming input fills the memory, then the block pulses start and waits for done. It then reads back result word 0 and presents it on a streaming output.

Parameters:
VECTOR_SIZE, 64, matrix/vector dimension; memory depth DEPTH = VECTOR_SIZE*VECTOR_SIZE+VECTOR_SIZE (4160 words)
ADDR_BITS, 13, word-address width decoded from BRAM_ADDR[ADDR_BITS+1:2]
TIMEOUT, 65535, max cycles in RUN waiting for done before abort

Ports:
aclk  in  1  clock; every register and the memory are clocked on its rising edge
areset  in  1  synchronous reset, active-high
s_data  in  32  host fill word
s_valid  in  1  fill word valid
s_ready  out  1  fill word accepted when s_valid&&s_ready
m_data  out  32  result word
m_valid  out  1  result valid
m_ready  in  1  result accepted when m_valid&&m_ready
start  out  1  one-cycle pulse to controller
done  in  1  controller completion pulse
BRAM_ADDR  in  32  controller byte address
BRAM_WRDATA  in  32  controller write data
BRAM_WE  in  4  controller byte write enables
BRAM_RDDATA  out  32  read data, registered
busy  out  1  high in every state except FILL
err  out  2  sticky: [0] BRAM access out of range or write during FILL, [1] RUN timeout

Behaviour:
- Reset values:
  - state=FILL, fill counter=0, watchdog=0.
  - s_ready=0 in the reset cycle, then 1. m_valid=0, m_data=0, start=0, BRAM_RDDATA=0, busy=0, err=0.
  - Memory contents are not cleared.
- Memory is dual-port.
  - Port A serves BRAM.
  - Port B serves the host (FILL writes, FETCH read).
  - Word index w = BRAM_ADDR[ADDR_BITS+1:2]. BRAM_ADDR[1:0] and bits above ADDR_BITS+1 are ignored.
- Port A read:
  - BRAM_RDDATA <= mem[w] every cycle, so read latency is exactly 1 cycle.
  - If w >= DEPTH: BRAM_RDDATA <= 0 and err[0] sets. This check applies only when BRAM_WE != 0 or state == RUN.
- Port A write:
  - For each i with BRAM_WE[i]=1, byte i of mem[w] <= BRAM_WRDATA[8i+7:8i]. Other bytes are unchanged.
  - Dropped, with err[0] set, if w >= DEPTH or state == FILL.
  - Read-during-write at the same w returns the old data.
- FSM: FILL -> START -> RUN -> FETCH -> OUT -> FILL.
  - FILL: s_ready=1. Each accepted beat writes mem[cnt] and increments cnt. The beat accepted with cnt==DEPTH-1 moves to START, and cnt returns to 0. s_ready=0 in every other state.
  - START: start=1 for exactly this one cycle, then RUN. Watchdog cleared.
  - RUN:
    - Watchdog increments each cycle.
    - done=1 -> FETCH.
    - Watchdog reaching TIMEOUT-1 without done -> err[1] set, FETCH.
    - If done arrives on the same cycle the watchdog expires, done wins and err[1] is not set.
    - done outside RUN is ignored.
  - FETCH: port B reads mem[0], one cycle, then OUT. A controller write to word 0 in the same cycle is not seen; the old data is returned.
  - OUT:
    - m_valid=1, m_data=captured word; both are held stable while m_ready=0.
    - On the handshake cycle: m_valid=0 next cycle, state -> FILL.
    - m_data keeps its last value after the handshake.
- busy = (state != FILL).
- Reset asserted mid-operation in any state returns to the reset values on the next edge. A half-finished fill restarts at address 0. err clears only on reset.

Test Plan:
- Fill 4160 beats, s_data=index, s_valid held high -> s_ready high throughout; start=1 exactly one cycle, the cycle after the 4160th accept; busy rises with START.
- In RUN, BRAM_ADDR=0x0000_0FFC (word 1023) -> BRAM_RDDATA=1023 next cycle; BRAM_ADDR=0x0000_4100 (word 4160) -> BRAM_RDDATA=0, err[0]=1.
- Controller model writes 0x1234_5678 to BRAM_ADDR=0, BRAM_WE=4'hF, then pulses done 5 cycles later -> m_valid=1, m_data=0x1234_5678. Hold m_ready=0 for 10 cycles: data stable. Raise m_ready: m_valid drops, s_ready=1 next cycle.
- Byte enables: mem[2]=0xAABB_CCDD; write 0x1122_3344 with BRAM_WE=4'b0011 -> read of word 2 returns 0xAABB_3344.
- TIMEOUT=100 override, no done -> err[1]=1 at RUN cycle 100. m_data = mem[0] contents (word 0 = 0 from the fill). Separately, done on the expiry cycle -> err[1]=0.
- Reset after 2000 fill beats -> s_ready=0 one cycle, err=0. Refill of 4160 beats starts at word 0: BRAM read of word 0 returns the new beat 0 value.

Source files
------------

// File: rtl/bram_host_agent.sv
// bram_host_agent: host-side owner of the controller's shared BRAM; fills it, starts the controller, returns result word 0
//   aclk/areset          : clock, synchronous active-high reset
//   s_data/s_valid/s_ready : host fill stream, one word per accepted beat, addresses 0..DEPTH-1
//   m_data/m_valid/m_ready : result stream, word 0 read back after done
//   start/done           : one-cycle start pulse out, completion pulse in
//   BRAM_*               : controller byte-addressed port, byte write enables, 1-cycle registered read
//   busy/err             : busy outside FILL; sticky err[0] bad access, err[1] run timeout
module bram_host_agent #(
  parameter int VECTOR_SIZE = 64,
  parameter int ADDR_BITS   = 13,
  parameter int TIMEOUT     = 65535
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        start,
  input  logic        done,
  input  logic [31:0] BRAM_ADDR,
  input  logic [31:0] BRAM_WRDATA,
  input  logic [3:0]  BRAM_WE,
  output logic [31:0] BRAM_RDDATA,
  output logic        busy,
  output logic [1:0]  err
);
  localparam int DEPTH = VECTOR_SIZE * VECTOR_SIZE + VECTOR_SIZE;
  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH - 1);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);
  typedef enum logic [2:0] {FILL, START, RUN, FETCH, OUT} state_t;
  state_t state, state_n;
  logic [31:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] w, cnt;
  logic [31:0] wd;
  logic live, accept, in_range, a_wr, expire;
  assign w        = BRAM_ADDR[ADDR_BITS+1:2];
  assign in_range = w <= LAST;
  // controller writes are refused while the host owns the memory
  assign a_wr     = |BRAM_WE && state != FILL && in_range;
  assign accept   = s_valid && s_ready && !areset;
  assign expire   = wd == WD_LAST;
  // live holds s_ready low for the first cycle after reset
  assign s_ready  = live && state == FILL;
  assign start    = state == START;
  assign m_valid  = state == OUT;
  assign busy     = state != FILL;
  always_comb begin
    state_n = state;
    unique case (state)
      FILL:    state_n = (accept && cnt == LAST) ? START : FILL;
      START:   state_n = RUN;
      RUN:     state_n = (done || expire) ? FETCH : RUN;
      FETCH:   state_n = OUT;
      OUT:     state_n = m_ready ? FILL : OUT;
      default: state_n = FILL;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= FILL;
      cnt         <= '0;
      wd          <= '0;
      live        <= 1'b0;
      m_data      <= '0;
      BRAM_RDDATA <= '0;
      err         <= '0;
    end else begin
      state       <= state_n;
      live        <= 1'b1;
      cnt         <= accept ? ((cnt == LAST) ? '0 : cnt + 1'b1) : cnt;
      wd          <= (state == RUN) ? wd + 1'b1 : '0;
      BRAM_RDDATA <= in_range ? mem[w] : '0;
      if (state == FETCH) m_data <= mem[0];
      if (((|BRAM_WE || state == RUN) && !in_range) || (|BRAM_WE && state == FILL)) err[0] <= 1'b1;
      if (state == RUN && expire && !done) err[1] <= 1'b1;
    end
  end
  // single memory array: port B writes only in FILL and port A writes never in FILL, so no write collision
  always_ff @(posedge aclk) begin
    if (accept) mem[cnt] <= s_data;
    for (int i = 0; i < 4; i++)
      if (a_wr && BRAM_WE[i]) mem[w][8*i +: 8] <= BRAM_WRDATA[8*i +: 8];
  end
endmodule

// File: tb/tb_bram_host_agent.sv
// tb_bram_host_agent: directed self-checking bench for bram_host_agent with a shortened watchdog
module tb_bram_host_agent;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        start;
  logic        done = 1'b0;
  logic [31:0] BRAM_ADDR = '0;
  logic [31:0] BRAM_WRDATA = '0;
  logic [3:0]  BRAM_WE = '0;
  logic [31:0] BRAM_RDDATA;
  logic        busy;
  logic [1:0]  err;
  int n_cmp = 0;
  int n_bad = 0;
  int rdy_bad, st_seen, hold_bad;
  bram_host_agent #(.VECTOR_SIZE(64), .ADDR_BITS(13), .TIMEOUT(100)) dut (
    .aclk(aclk), .areset(areset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .start(start), .done(done),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_WRDATA(BRAM_WRDATA), .BRAM_WE(BRAM_WE),
    .BRAM_RDDATA(BRAM_RDDATA), .busy(busy), .err(err)
  );
  always #5 aclk = ~aclk;
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic fill(input logic [31:0] base, input int n);
    rdy_bad = 0;
    st_seen = 0;
    for (int i = 0; i < n; i++) begin
      s_data = base + i;
      s_valid = 1'b1;
      if (s_ready !== 1'b1) rdy_bad++;
      if (start !== 1'b0) st_seen++;
      tick();
    end
    s_valid = 1'b0;
  endtask
  initial begin
    tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_start", start, 0);
    check("rst_rddata", BRAM_RDDATA, 0);
    areset = 1'b0;
    tick();
    check("s_ready_after_rst", s_ready, 1);
    fill(32'h0, 4160);
    check("fill_ready_gaps", rdy_bad, 0);
    check("fill_early_start", st_seen, 0);
    check("start_pulse", start, 1);
    check("start_busy", busy, 1);
    check("start_s_ready", s_ready, 0);
    tick();
    check("start_one_cycle", start, 0);
    BRAM_ADDR = 32'h0000_0FFC;
    tick();
    check("rd_word1023", BRAM_RDDATA, 1023);
    check("err_clean", err, 0);
    BRAM_ADDR = 32'h0000_4100;
    tick();
    check("rd_oob_data", BRAM_RDDATA, 0);
    check("rd_oob_err", err, 2'b01);
    BRAM_ADDR = 32'h8;
    BRAM_WRDATA = 32'hAABB_CCDD;
    BRAM_WE = 4'hF;
    tick();
    BRAM_WRDATA = 32'h1122_3344;
    BRAM_WE = 4'b0011;
    tick();
    check("rd_during_wr_old", BRAM_RDDATA, 32'hAABB_CCDD);
    BRAM_WE = 4'h0;
    tick();
    check("byte_enable_merge", BRAM_RDDATA, 32'hAABB_3344);
    BRAM_ADDR = 32'h0;
    BRAM_WRDATA = 32'h1234_5678;
    BRAM_WE = 4'hF;
    tick();
    BRAM_WE = 4'h0;
    for (int i = 0; i < 5; i++) tick();
    check("run_waits_done", m_valid, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("out_valid", m_valid, 1);
    check("out_data", m_data, 32'h1234_5678);
    check("no_timeout_err", err, 2'b01);
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_valid !== 1'b1 || m_data !== 32'h1234_5678) hold_bad++;
    end
    check("out_hold_stable", hold_bad, 0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("hs_valid_drop", m_valid, 0);
    check("hs_s_ready", s_ready, 1);
    check("hs_data_kept", m_data, 32'h1234_5678);
    check("hs_busy", busy, 0);
    fill(32'h0, 4160);
    check("fill2_ready_gaps", rdy_bad, 0);
    tick();
    for (int i = 0; i < 98; i++) tick();
    check("to_cycle99_err", err, 2'b01);
    check("to_cycle99_running", busy, 1);
    tick();
    check("to_cycle100_err", err, 2'b01);
    tick();
    check("to_expired_err", err, 2'b11);
    tick();
    check("to_out_valid", m_valid, 1);
    check("to_out_data", m_data, 0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    fill(32'h0010_0000, 2000);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("midrst_s_ready", s_ready, 0);
    check("midrst_err", err, 0);
    check("midrst_busy", busy, 0);
    tick();
    check("midrst_s_ready_up", s_ready, 1);
    fill(32'h0000_5000, 4160);
    check("refill_ready_gaps", rdy_bad, 0);
    check("refill_start", start, 1);
    tick();
    BRAM_ADDR = 32'h0;
    tick();
    check("refill_word0", BRAM_RDDATA, 32'h0000_5000);
    for (int i = 0; i < 98; i++) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("done_at_expiry_err", err, 0);
    check("done_at_expiry_fetch", m_valid, 0);
    tick();
    check("done_at_expiry_out", m_valid, 1);
    check("done_at_expiry_data", m_data, 32'h0000_5000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
